// File: rtl/rotary_decoder.sv
// Quadrature rotary encoder front end: synchronize, debounce, detect detent steps.
// Optional detent position counter is compiled in when ROTARY_POS_COUNT_EN is defined.
module rotary_decoder #(
  parameter logic [15:0] DEB_CYCLES = 16'd5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rot_a,
  input  logic       rot_b,
  output logic       rot_event,
  output logic       rot_dir,
  output logic       step_pulse,
  output logic [7:0] pos
);

  logic        a_s1, a_s2, b_s1, b_s2;
  logic        a_filt, b_filt;
  logic [15:0] a_cnt, b_cnt;
  logic        q1, q1_d, q2;
  logic        dir_q;
  logic        step_det;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_s1 <= 1'b0;
      a_s2 <= 1'b0;
      b_s1 <= 1'b0;
      b_s2 <= 1'b0;
    end else begin
      a_s1 <= rot_a;
      a_s2 <= a_s1;
      b_s1 <= rot_b;
      b_s2 <= b_s1;
    end
  end

  // Filtered value follows only after DEB_CYCLES consecutive differing cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_filt <= 1'b0;
      a_cnt  <= 16'd0;
    end else if (a_s2 != a_filt) begin
      if (a_cnt == DEB_CYCLES - 16'd1) begin
        a_filt <= a_s2;
        a_cnt  <= 16'd0;
      end else begin
        a_cnt <= a_cnt + 16'd1;
      end
    end else begin
      a_cnt <= 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_filt <= 1'b0;
      b_cnt  <= 16'd0;
    end else if (b_s2 != b_filt) begin
      if (b_cnt == DEB_CYCLES - 16'd1) begin
        b_filt <= b_s2;
        b_cnt  <= 16'd0;
      end else begin
        b_cnt <= b_cnt + 16'd1;
      end
    end else begin
      b_cnt <= 16'd0;
    end
  end

  // q1 marks an excursion that reached 11 after 00; q2 remembers which phase led.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
    end else begin
      case ({a_filt, b_filt})
        2'b11: q1 <= 1'b1;
        2'b00: q1 <= 1'b0;
        default: q1 <= q1;
      endcase
      case ({a_filt, b_filt})
        2'b01: q2 <= 1'b1;
        2'b10: q2 <= 1'b0;
        default: q2 <= q2;
      endcase
    end
  end

  assign step_det = q1 & ~q1_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q1_d       <= 1'b0;
      step_pulse <= 1'b0;
      dir_q      <= 1'b0;
    end else begin
      q1_d       <= q1;
      step_pulse <= step_det;
      dir_q      <= rot_dir;
    end
  end

  // Direction is presented during the detect cycle, one cycle ahead of rot_event.
  assign rot_dir   = step_det ? q2 : dir_q;
  assign rot_event = q1_d;

`ifdef ROTARY_POS_COUNT_EN
  logic [7:0] pos_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_q <= 8'd0;
    end else if (step_pulse) begin
      pos_q <= dir_q ? pos_q + 8'd1 : pos_q - 8'd1;
    end
  end

  assign pos = pos_q;
`else
  assign pos = 8'd0;
`endif

endmodule

// File: tb/tb_rotary_decoder.sv
// Scoreboard bench for rotary_decoder with DEB_CYCLES=4: stimulus pushes expected
// steps, a negedge monitor pops and checks them whenever step_pulse appears.
module tb_rotary_decoder;

  localparam int LATENCY = 8;

  typedef struct {
    logic dir;
    int   cyc;
  } step_t;

  logic       clk;
  logic       rst_n;
  logic       rot_a;
  logic       rot_b;
  logic       rot_event;
  logic       rot_dir;
  logic       step_pulse;
  logic [7:0] pos;

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  step_t sb[$];
  logic [7:0] model_pos = 8'd0;
  logic  prev_dir = 1'b0;
  logic  prev_event = 1'b0;

  rotary_decoder #(.DEB_CYCLES(16'd4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rot_a      (rot_a),
    .rot_b      (rot_b),
    .rot_event  (rot_event),
    .rot_dir    (rot_dir),
    .step_pulse (step_pulse),
    .pos        (pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [7:0] exp_pos();
`ifdef ROTARY_POS_COUNT_EN
    return model_pos;
`else
    return 8'd0;
`endif
  endfunction

  // Monitor: every step_pulse must match the oldest expected step.
  always @(negedge clk) begin
    if (step_pulse === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_step", 1, 0);
      end else begin
        step_t e;
        e = sb.pop_front();
        checkOutput("step_cycle", cyc, e.cyc);
        checkOutput("step_dir", int'(rot_dir), int'(e.dir));
        checkOutput("dir_before_event", int'(prev_dir), int'(e.dir));
        checkOutput("event_high", int'(rot_event), 1);
        checkOutput("event_rising", int'(prev_event), 0);
      end
    end
    prev_dir   = rot_dir;
    prev_event = rot_event;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Called at a negedge; drives (a,b), optionally queues the step it completes.
  task automatic applyStimulus(input logic a, input logic b, input int hold,
                               input logic push, input logic dir);
    step_t e;
    rot_a = a;
    rot_b = b;
    if (push) begin
      e.dir = dir;
      e.cyc = cyc + LATENCY;
      sb.push_back(e);
      model_pos = dir ? model_pos + 8'd1 : model_pos - 8'd1;
    end
    repeat (hold) @(negedge clk);
  endtask

  task automatic do_step(input logic dir);
    if (dir) begin
      applyStimulus(1'b0, 1'b1, 20, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 20, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 20, 1'b0, 1'b0);
    end else begin
      applyStimulus(1'b1, 1'b0, 20, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 20, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 20, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 20, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_event"}, int'(rot_event), 0);
    checkOutput({tag, "_dir"}, int'(rot_dir), 0);
    checkOutput({tag, "_pulse"}, int'(step_pulse), 0);
    checkOutput({tag, "_pos"}, int'(pos), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    rot_a = 1'b0;
    rot_b = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_release");

    // Three A-leads steps then four B-leads steps, with position checks.
    repeat (3) do_step(1'b0);
    checkOutput("pos_after_down", int'(pos), int'(exp_pos()));
    repeat (4) do_step(1'b1);
    checkOutput("pos_after_up", int'(pos), int'(exp_pos()));

    // Short glitch on rot_a while idle at 00 must never reach the filter.
    rot_a = 1'b1;
    repeat (3) @(negedge clk);
    rot_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checkOutput("glitch_filtered_a", int'(dut.a_filt), 0);
      @(negedge clk);
    end
    checkOutput("glitch_no_event", int'(rot_event), 0);

    // Step into 11, then bounce one phase repeatedly without visiting 00.
    applyStimulus(1'b0, 1'b1, 20, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 20, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 20, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 20, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 20, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 20, 1'b0, 1'b0);
      checkOutput("reversal_event_held", int'(rot_event), 1);
    end
    checkOutput("reversal_dir", int'(rot_dir), 1);
    applyStimulus(1'b1, 1'b0, 20, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 20, 1'b0, 1'b0);
    checkOutput("pos_after_reversals", int'(pos), int'(exp_pos()));

    // Reset while the 11 edge is mid-debounce (counter at 2).
    applyStimulus(1'b0, 1'b1, 20, 1'b0, 1'b0);
    rot_a = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("mid_debounce_count", int'(dut.a_cnt), 2);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    model_pos = 8'd0;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1, 1'b1, 1'b0);
    check_all_zero("mid_release");
    repeat (30) @(negedge clk);
    checkOutput("pos_after_reset_step", int'(pos), int'(exp_pos()));
    checkOutput("reset_step_event", int'(rot_event), 1);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rotary_decoder.md
ROTARY_DECODER -- requirements
Module: rotary_decoder

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 16'd5000, meaning the consecutive stable cycles required before a filtered input changes (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port rot_a  input  1  asynchronous quadrature phase A from the shaft encoder.
REQ-005 SHALL have port rot_b  input  1  asynchronous quadrature phase B from the shaft encoder.
REQ-006 SHALL have port rot_event  output  1  level signal; one rising edge per detent step.
REQ-007 SHALL have port rot_dir  output  1  direction of the most recent step: 1 = B-leads sequence, 0 = A-leads sequence.
REQ-008 SHALL have port step_pulse  output  1  one-cycle strobe, high in the same cycle rot_event rises.
REQ-009 SHALL have port pos  output  8  signed-agnostic detent position count (see Configuration).

Function
REQ-010 SHALL pass rot_a and rot_b each through a two-flop synchronizer before any other use.
REQ-011 SHALL debounce each synchronized input independently: the filtered value takes the synchronized value only after they differ for DEB_CYCLES consecutive cycles; the per-input 16-bit counter clears in any cycle they are equal.
REQ-012 SHALL derive q1 from filtered (a,b): 11 sets q1=1, 00 clears q1=0, 01/10 hold.
REQ-013 SHALL derive q2 from filtered (a,b): 01 sets q2=1, 10 clears q2=0, 00/11 hold.
REQ-014 SHALL register q1_d (q1 delayed one cycle) and detect a step as q1=1 and q1_d=0.
REQ-015 SHALL load rot_dir with q2 in the cycle a step is detected; rot_dir otherwise holds.
REQ-016 SHALL drive rot_event from q1_d, so rot_dir is stable at least one full cycle before rot_event rises.
REQ-017 SHALL assert step_pulse for exactly one cycle, coincident with the rot_event rising edge.
REQ-018 SHALL produce no step for filtered transitions that do not pass through 00 then 11 (e.g. 11->10->11, 11->01->11).
REQ-019 SHALL produce latency from a clean input edge completing 00->x->11 to rot_event rising of 2 (sync) + DEB_CYCLES (filter) + 1 (q1) + 1 (q1_d) cycles.
REQ-020 SHALL generate at most one step per 00->11 excursion regardless of direction reversals in between.

Reset
REQ-021 SHALL, while rst_n=0 at a clk edge, clear synchronizer flops, filtered values, debounce counters, q1, q1_d, q2, rot_dir, step_pulse and pos to 0.
REQ-022 SHALL discard any in-progress debounce count on reset; after release, an input already at 11 produces one step after full latency (REQ-019).
REQ-023 SHALL hold all outputs at 0 in the first cycle after rst_n returns to 1.

Configuration
REQ-024 SHALL compile the position counter only when macro ROTARY_POS_COUNT_EN is defined.
REQ-025 SHALL, with ROTARY_POS_COUNT_EN defined, increment pos on each step_pulse with the newly loaded rot_dir=1 and decrement it when rot_dir=0, wrapping modulo 256 (255+1=0, 0-1=255).
REQ-026 SHALL, without ROTARY_POS_COUNT_EN, tie pos to 8'd0 and instantiate no counter logic; all other behaviour unchanged.

Verification
REQ-027 SHALL cover: DEB_CYCLES=4, reset, drive (a,b) 00->01->11 each held 20 cycles -> exactly one step_pulse, rot_dir=1, rot_event rises 8 cycles after b=1->a=1 edge reaches 11.
REQ-028 SHALL cover: same bench, 00->10->11 -> one step_pulse, rot_dir=0, rot_dir valid one cycle before rot_event rises.
REQ-029 SHALL cover: glitch on rot_a lasting 3 cycles (< DEB_CYCLES=4) during 00 -> no change in filtered value, no step_pulse.
REQ-030 SHALL cover: 11->10->11 and 11->01->11 repeated 5 times -> zero step_pulses, rot_event stays 1.
REQ-031 SHALL cover: with ROTARY_POS_COUNT_EN, 3 steps dir=0 from reset -> pos=253; then 4 steps dir=1 -> pos=1; without the macro pos=0 throughout.
REQ-032 SHALL cover: rst_n pulled low mid-debounce (counter=2) with input at 11 -> outputs 0 next cycle; after release, one step after full latency.
